// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the counter scheduler
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_NOP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter; search starts one past the last advanced winner
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          grant,
  output logic [$clog2(NREQ)-1:0]  grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;
  logic [IW-1:0] cand;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = IW'(idx);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        found       = 1'b1;
      end
    end
  end

  // Pointer moves only when the winner is actually taken by the owner FSM.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - arbitrates requester commands onto one shared up/down counter
module counter_scheduler
  import counter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][1:0]        req_op,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_arg,
  output logic [NREQ-1:0]             done,
  output logic [WIDTH-1:0]            result,
  output logic [WIDTH-1:0]            cnt_data_in,
  output logic                        cnt_load_en,
  output logic                        cnt_count_en,
  output logic                        cnt_up_down,
  input  logic [WIDTH-1:0]            cnt_q,
  output logic                        busy,
  output logic [$clog2(NREQ)-1:0]     grant_id
);

  localparam int IW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] arg_q, arg_d;
  logic [WIDTH-1:0] steps_q, steps_d;

  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             advance;
  op_e              new_op;
  logic [WIDTH-1:0] new_arg;

  // Requests are only visible to the arbiter while idle, so ready stays low when busy.
  assign arb_req   = (state_q == ST_IDLE) ? req_valid : '0;
  assign req_ready = arb_grant;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (arb_req),
    .advance   (advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    op_d    = op_q;
    arg_d   = arg_q;
    steps_d = steps_q;
    advance = 1'b0;
    new_op  = op_e'(req_op[arb_idx]);
    new_arg = req_arg[arb_idx];
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          advance = 1'b1;
          owner_d = arb_idx;
          op_d    = new_op;
          arg_d   = new_arg;
          steps_d = new_arg;
          unique case (new_op)
            OP_LOAD:        state_d = ST_LOAD;
            OP_UP, OP_DOWN: state_d = (new_arg == '0) ? ST_DONE : ST_RUN;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_RUN: begin
        steps_d = steps_q - WIDTH'(1);
        if (steps_q <= WIDTH'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter controls decode straight from state so reset removes them without a clock.
  always_comb begin
    cnt_load_en  = (state_q == ST_LOAD);
    cnt_count_en = (state_q == ST_RUN);
    cnt_up_down  = (state_q == ST_RUN) && (op_q == OP_UP);
    cnt_data_in  = (state_q == ST_LOAD) ? arg_q : '0;
    busy         = (state_q != ST_IDLE);
    grant_id     = owner_q;
    done         = '0;
    result       = '0;
    if (state_q == ST_DONE) begin
      done[owner_q] = 1'b1;
      result        = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      op_q    <= OP_LOAD;
      arg_q   <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      steps_q <= steps_d;
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// tb/tb_counter_scheduler.sv - scoreboard bench for counter_scheduler with a behavioural shared counter
module tb_counter_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam logic [1:0] OPL = 2'd0, OPU = 2'd1, OPD = 2'd2, OPN = 2'd3;

  logic                       clk = 1'b0;
  logic                       reset_n = 1'b0;
  logic [NREQ-1:0]            req_valid = '0;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][1:0]       req_op = '0;
  logic [NREQ-1:0][WIDTH-1:0] req_arg = '0;
  logic [NREQ-1:0]            done;
  logic [WIDTH-1:0]           result;
  logic [WIDTH-1:0]           cnt_data_in;
  logic                       cnt_load_en, cnt_count_en, cnt_up_down;
  logic [WIDTH-1:0]           cnt_q;
  logic                       busy;
  logic [1:0]                 grant_id;

  counter_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_arg      (req_arg),
    .done         (done),
    .result       (result),
    .cnt_data_in  (cnt_data_in),
    .cnt_load_en  (cnt_load_en),
    .cnt_count_en (cnt_count_en),
    .cnt_up_down  (cnt_up_down),
    .cnt_q        (cnt_q),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          cnt_q <= '0;
    else if (cnt_load_en)  cnt_q <= cnt_data_in;
    else if (cnt_count_en) cnt_q <= cnt_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end

  typedef struct {
    int         id;
    int         due;
    logic [3:0] res;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [3:0] model_cnt = '0;
  logic [3:0] last_result = '0;

  always @(negedge clk) begin : monitor
    exp_t e;
    int   aid;
    int   lat;
    logic [1:0] aop;
    logic [3:0] aarg;
    cyc++;
    if (!reset_n) begin
      sb.delete();
      model_cnt = '0;
    end else begin
      checks++;
      if (cnt_load_en && cnt_count_en) begin
        errors++;
        $display("FAIL enable_overlap: load_en=%0b count_en=%0b, required not both high", cnt_load_en, cnt_count_en);
      end
      checks++;
      if ($countones(req_ready) > 1) begin
        errors++;
        $display("FAIL ready_onehot: req_ready=%b, required at most one bit", req_ready);
      end
      checks++;
      if ($countones(done) > 1) begin
        errors++;
        $display("FAIL done_onehot: done=%b, required at most one bit", done);
      end
      if (|done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=%b at cycle %0d, required no pulse", done, cyc);
        end else begin
          e = sb.pop_front();
          last_result = result;
          checks++;
          if (done !== (4'b0001 << e.id)) begin
            errors++;
            $display("FAIL done_owner: done=%b, required one-hot bit %0d", done, e.id);
          end
          checks++;
          if (cyc !== e.due) begin
            errors++;
            $display("FAIL done_latency: done at cycle %0d, required cycle %0d", cyc, e.due);
          end
          checks++;
          if (result !== e.res) begin
            errors++;
            $display("FAIL done_result: result=%h, required %h", result, e.res);
          end
        end
      end
      if (|(req_valid & req_ready)) begin
        aid = 0;
        for (int i = 0; i < NREQ; i++) if (req_valid[i] && req_ready[i]) aid = i;
        aop  = req_op[aid];
        aarg = req_arg[aid];
        case (aop)
          OPL: begin lat = 2; model_cnt = aarg; end
          OPU: begin lat = (aarg == 0) ? 1 : int'(aarg) + 1; model_cnt = model_cnt + aarg; end
          OPD: begin lat = (aarg == 0) ? 1 : int'(aarg) + 1; model_cnt = model_cnt - aarg; end
          default: lat = 1;
        endcase
        e.id  = aid;
        e.due = cyc + lat;
        e.res = model_cnt;
        sb.push_back(e);
      end
    end
  end

  task automatic issue(input int id, input logic [1:0] op, input logic [3:0] arg,
                       output int gid, output bit ok);
    @(posedge clk); #1;
    req_valid     = '0;
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_arg[id]   = arg;
    ok  = 1'b0;
    gid = -1;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); #1;
      if (|(req_valid & req_ready)) begin
        ok = 1'b1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
      end
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic watch(output int nload, output int ncnt, output int nup, output int nbad,
                       output logic [3:0] ldata, output bit ok);
    nload = 0; ncnt = 0; nup = 0; nbad = 0; ldata = '0; ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (cnt_load_en) begin nload++; ldata = cnt_data_in; end
      if (cnt_count_en) ncnt++;
      if (cnt_count_en && cnt_up_down) nup++;
      if (busy && req_ready != '0) nbad++;
      #1;
      if (sb.size() == 0) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: got %b, required 0000", done); end
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    checks++; if ({cnt_load_en, cnt_count_en, cnt_up_down} !== 3'b0) begin
      errors++; $display("FAIL reset_cnt_ctrl: got %b, required 000", {cnt_load_en, cnt_count_en, cnt_up_down});
    end
    checks++; if (result !== 4'h0 || cnt_data_in !== 4'h0) begin
      errors++; $display("FAIL reset_data: result=%h data_in=%h, required 0 and 0", result, cnt_data_in);
    end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d, required 0", grant_id); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_round_robin();
    int ids[5];
    int cys[5];
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin req_op[i] = OPN; req_arg[i] = '0; end
    req_valid = '1;
    for (int k = 0; k < 40 && n < 5; k++) begin
      @(negedge clk); #1;
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) ids[n] = i;
        cys[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    checks++;
    if (n !== 5) begin errors++; $display("FAIL rr_accept_count: got %0d, required 5", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (ids[i] !== exp_ids[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d, required %0d", i, ids[i], exp_ids[i]); end
      if (i > 0) begin
        checks++;
        if (cys[i] - cys[i-1] !== 2) begin
          errors++; $display("FAIL rr_back_to_back[%0d]: gap %0d, required 2", i, cys[i] - cys[i-1]);
        end
      end
    end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_drain: timeout, required idle"); end
  endtask

  task automatic test_load();
    int gid, nl, nc, nu, nb;
    logic [3:0] ld;
    bit ok, ok2;
    issue(1, OPL, 4'hA, gid, ok);
    checks++; if (!ok || gid !== 1) begin errors++; $display("FAIL load_accept: ok=%0b gid=%0d, required 1 and 1", ok, gid); end
    watch(nl, nc, nu, nb, ld, ok2);
    checks++; if (!ok2) begin errors++; $display("FAIL load_done_timeout: no done, required done"); end
    checks++; if (nl !== 1) begin errors++; $display("FAIL load_en_cycles: got %0d, required 1", nl); end
    checks++; if (ld !== 4'hA) begin errors++; $display("FAIL load_data_in: got %h, required a", ld); end
    checks++; if (nc !== 0) begin errors++; $display("FAIL load_count_en: got %0d, required 0", nc); end
    checks++; if (last_result !== 4'hA) begin errors++; $display("FAIL load_result: got %h, required a", last_result); end
  endtask

  task automatic test_up_wrap();
    int gid, nl, nc, nu, nb;
    logic [3:0] ld;
    bit ok, ok2;
    issue(0, OPL, 4'hE, gid, ok);
    watch(nl, nc, nu, nb, ld, ok2);
    checks++; if (!ok || !ok2 || last_result !== 4'hE) begin
      errors++; $display("FAIL preload_e: ok=%0b/%0b result=%h, required e", ok, ok2, last_result);
    end
    issue(0, OPU, 4'd3, gid, ok);
    checks++; if (!ok || gid !== 0) begin errors++; $display("FAIL up_accept: ok=%0b gid=%0d, required 1 and 0", ok, gid); end
    watch(nl, nc, nu, nb, ld, ok2);
    checks++; if (nc !== 3) begin errors++; $display("FAIL up_count_cycles: got %0d, required 3", nc); end
    checks++; if (nu !== 3) begin errors++; $display("FAIL up_direction: up cycles %0d, required 3", nu); end
    checks++; if (nl !== 0) begin errors++; $display("FAIL up_no_load: got %0d, required 0", nl); end
    checks++; if (last_result !== 4'h1) begin errors++; $display("FAIL up_wrap_result: got %h, required 1", last_result); end
  endtask

  task automatic test_down();
    int gid, nl, nc, nu, nb;
    logic [3:0] ld;
    bit ok, ok2;
    issue(2, OPD, 4'd0, gid, ok);
    watch(nl, nc, nu, nb, ld, ok2);
    checks++; if (!ok || gid !== 2) begin errors++; $display("FAIL down0_accept: ok=%0b gid=%0d, required 1 and 2", ok, gid); end
    checks++; if (nc !== 0 || nl !== 0) begin errors++; $display("FAIL down0_enables: count=%0d load=%0d, required 0 and 0", nc, nl); end
    checks++; if (last_result !== 4'h1) begin errors++; $display("FAIL down0_result: got %h, required 1", last_result); end
    issue(3, OPD, 4'd2, gid, ok);
    watch(nl, nc, nu, nb, ld, ok2);
    checks++; if (nc !== 2 || nu !== 0) begin errors++; $display("FAIL down2_enables: count=%0d up=%0d, required 2 and 0", nc, nu); end
    checks++; if (last_result !== 4'hF) begin errors++; $display("FAIL down_wrap_result: got %h, required f", last_result); end
  endtask

  task automatic test_busy_ignore();
    int gid, nl, nc, nu, nb;
    logic [3:0] ld;
    bit ok, ok2, got;
    issue(3, OPU, 4'd4, gid, ok);
    req_valid[2] = 1'b1; req_op[2] = OPN; req_arg[2] = 4'd0;
    req_op[3] = OPD; req_arg[3] = 4'd1;
    watch(nl, nc, nu, nb, ld, ok2);
    checks++; if (nc !== 4 || nu !== 4) begin errors++; $display("FAIL busy_latched_cmd: count=%0d up=%0d, required 4 and 4", nc, nu); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL busy_ready: %0d cycles with ready, required 0", nb); end
    checks++; if (last_result !== 4'h3) begin errors++; $display("FAIL busy_result: got %h, required 3", last_result); end
    got = 1'b0; gid = -1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); #1;
      if (|(req_valid & req_ready)) begin
        got = 1'b1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (!got || gid !== 2) begin errors++; $display("FAIL pending_grant: got=%0b id=%0d, required 1 and 2", got, gid); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_drain: timeout, required idle"); end
  endtask

  task automatic test_reset_abort();
    int gid, ndone;
    bit ok, got;
    issue(1, OPU, 4'd5, gid, ok);
    @(posedge clk); #1;
    checks++; if (cnt_count_en !== 1'b1) begin errors++; $display("FAIL abort_running: count_en=%b, required 1", cnt_count_en); end
    reset_n = 1'b0;
    #1;
    checks++; if (cnt_count_en !== 1'b0 || cnt_load_en !== 1'b0) begin
      errors++; $display("FAIL abort_enables: count=%b load=%b, required 0 and 0", cnt_count_en, cnt_load_en);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (|done) ndone++;
    end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort_no_done: %0d pulses, required 0", ndone); end
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin req_op[i] = OPN; req_arg[i] = '0; end
    req_valid = '1;
    got = 1'b0; gid = -1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); #1;
      if (|(req_valid & req_ready)) begin
        got = 1'b1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (!got || gid !== 0) begin errors++; $display("FAIL abort_rr_restart: got=%0b id=%0d, required 1 and 0", got, gid); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_drain: timeout, required idle"); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_load();
    test_up_wrap();
    test_down();
    test_busy_ignore();
    test_reset_abort();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WIDTH, default 4, counter data width; matches the shared counter.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  NREQ  per-requester command valid.
REQ-006 req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-007 req_op  input  NREQ x 2  per-requester op: LOAD=0, UP=1, DOWN=2, NOP=3.
REQ-008 req_arg  input  NREQ x WIDTH  load value (LOAD) or step count (UP/DOWN).
REQ-009 done  output  NREQ  one-cycle completion pulse to the owning requester.
REQ-010 result  output  WIDTH  counter value; valid in the cycle done is high.
REQ-011 cnt_data_in, cnt_load_en, cnt_count_en, cnt_up_down  outputs  WIDTH,1,1,1  drive the shared counter.
REQ-012 cnt_q  input  WIDTH  counter output fed back.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 grant_id  output  clog2(NREQ)  index of the current owner; holds its last value in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-016 In IDLE, req_ready SHALL be asserted combinationally for the round-robin winner among valid requesters; the command is accepted when req_valid & req_ready.
REQ-017 Round-robin SHALL start the search at the index after the last accepted requester; after reset the search starts at index 0.
REQ-018 Accept transitions: LOAD op -> LOAD; UP/DOWN op with arg>0 -> RUN; UP/DOWN op with arg=0 -> DONE; NOP -> DONE.
REQ-019 LOAD SHALL assert cnt_load_en=1 and cnt_data_in=arg for exactly one cycle, then go to DONE.
REQ-020 RUN SHALL assert cnt_count_en=1 for exactly arg consecutive cycles, with cnt_up_down=1 for UP and 0 for DOWN, then go to DONE.
REQ-021 DONE SHALL pulse done[owner] for one cycle with result=cnt_q, then go to IDLE.
REQ-022 Accept-to-done latency SHALL be 2 cycles for LOAD, arg+1 for UP/DOWN, and 1 for NOP or a zero-step op.
REQ-023 cnt_load_en and cnt_count_en SHALL never be high together and SHALL be 0 outside LOAD and RUN.
REQ-024 The scheduler SHALL NOT saturate; counter wrap-around (F+1 -> 0, 0-1 -> F at WIDTH=4) passes through to result.
REQ-025 Command fields SHALL be latched at accept; requester inputs are ignored while busy, and req_ready=0 while busy.
REQ-026 A requester that deasserts req_valid before a grant loses nothing; no grant is issued for it.
REQ-027 Back-to-back operation: IDLE may accept in the cycle after DONE; no command is accepted in DONE itself.

Reset
REQ-028 On reset_n=0 the block SHALL immediately enter IDLE with all outputs 0, the RR pointer cleared and the step counter 0.
REQ-029 A reset during LOAD/RUN/DONE SHALL abort the command with no done pulse; cnt_* enables SHALL drop asynchronously.

Structure
REQ-030 Package counter_pkg SHALL hold the op_e enum, state_e enum and the default WIDTH constant.
REQ-031 Round-robin selection SHALL be a sub-module, rr_arbiter (NREQ request inputs, one-hot grant output, advance strobe).
REQ-032 The step counter SHALL be WIDTH bits and loaded from arg at accept.

Verification
REQ-033 LOAD 4'hA from req 1 -> one cycle with cnt_load_en=1 and cnt_data_in=A; done[1] 2 cycles after accept with result=A.
REQ-034 cnt_q=E, UP arg=3 from req 0 -> cnt_count_en high for 3 cycles with up_down=1; done[0] with result=1 (wrap).
REQ-035 All 4 requesters valid continuously with NOPs -> grants in order 0,1,2,3,0; each done 1 cycle after its accept.
REQ-036 DOWN arg=0 -> no cnt_count_en; done 1 cycle after accept with result unchanged.
REQ-037 reset_n pulsed low in cycle 2 of RUN with arg=5 -> enables drop immediately; no done pulse; next accept goes to req 0.
REQ-038 Assertion, checked every cycle: not (cnt_load_en & cnt_count_en); popcount(req_ready) <= 1; popcount(done) <= 1.
